// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped IO bus controller: decodes CPU accesses into N_CH channels with a req/ack handshake.
// Optional ack timeout enabled by defining MMIO_TIMEOUT_EN.
module mmio_bus_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FC00,
    parameter int unsigned SPAN_LOG2 = 4,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req_i,
    input  logic                   cpu_we_i,
    input  logic [31:0]            cpu_addr_i,
    input  logic [DATA_W-1:0]      cpu_wdata_i,
    output logic [DATA_W-1:0]      cpu_rdata_o,
    output logic                   cpu_ready_o,
    output logic                   cpu_err_o,
    output logic                   is_io_o,
    output logic                   stall_o,
    output logic [N_CH-1:0]        ch_req_o,
    output logic                   ch_we_o,
    output logic [SPAN_LOG2-1:0]   ch_offset_o,
    output logic [DATA_W-1:0]      ch_wdata_o,
    input  logic [N_CH*DATA_W-1:0] ch_rdata_i,
    input  logic [N_CH-1:0]        ch_ack_i
);

    localparam int unsigned IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [31:0] WIN_BYTES = 32'(N_CH) << SPAN_LOG2;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  we_q, we_d;
    logic [SPAN_LOG2-1:0]  off_q, off_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic [31:0]           addr_off;
    logic [IDX_W-1:0]      idx_dec;
    logic                  ack_sel;
    logic [DATA_W-1:0]     rdata_sel;

    // Offset from the window base; comparing it against the window size avoids end-address overflow.
    assign addr_off  = cpu_addr_i - BASE_ADDR;
    assign is_io_o   = (cpu_addr_i >= BASE_ADDR) && (addr_off < WIN_BYTES);
    assign idx_dec   = IDX_W'(addr_off >> SPAN_LOG2);
    assign ack_sel   = ch_ack_i[idx_q];
    assign rdata_sel = ch_rdata_i[32'(idx_q) * DATA_W +: DATA_W];

`ifdef MMIO_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MMIO_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MMIO_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MMIO_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cpu_req_i && is_io_o) begin
                    state_d = StReq;
                    idx_d   = idx_dec;
                    we_d    = cpu_we_i;
                    off_d   = cpu_addr_i[SPAN_LOG2-1:0];
                    wdata_d = cpu_wdata_i;
`ifdef MMIO_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            StReq: begin
                // An ack in the final timeout cycle still completes normally.
                if (ack_sel) begin
                    state_d = StDone;
                    rdata_d = we_q ? '0 : rdata_sel;
`ifdef MMIO_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = StDone;
                    rdata_d = '1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign ch_req_o    = (state_q == StReq) ? (N_CH'(1) << idx_q) : '0;
    assign cpu_ready_o = (state_q == StDone);
    assign stall_o     = cpu_req_i && is_io_o && (state_q != StDone);
    assign ch_we_o     = we_q;
    assign ch_offset_o = off_q;
    assign ch_wdata_o  = wdata_q;
    assign cpu_rdata_o = rdata_q;
`ifdef MMIO_TIMEOUT_EN
    assign cpu_err_o   = cpu_ready_o && err_q;
`else
    assign cpu_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed bench for mmio_bus_ctrl: address-decode vector table plus handshake sequences.
// Timeout sequences run only when MMIO_TIMEOUT_EN is defined.
module tb_mmio_bus_ctrl;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned N_CH      = 4;
    localparam int unsigned SPAN_LOG2 = 4;

    logic                   clk;
    logic                   rst;
    logic                   cpu_req;
    logic                   cpu_we;
    logic [31:0]            cpu_addr;
    logic [DATA_W-1:0]      cpu_wdata;
    logic [DATA_W-1:0]      cpu_rdata;
    logic                   cpu_ready;
    logic                   cpu_err;
    logic                   is_io;
    logic                   stall;
    logic [N_CH-1:0]        ch_req;
    logic                   ch_we;
    logic [SPAN_LOG2-1:0]   ch_offset;
    logic [DATA_W-1:0]      ch_wdata;
    logic [N_CH*DATA_W-1:0] ch_rdata;
    logic [N_CH-1:0]        ch_ack;

    mmio_bus_ctrl #(
        .DATA_W    (DATA_W),
        .BASE_ADDR (32'hFFFF_FC00),
        .SPAN_LOG2 (SPAN_LOG2),
        .N_CH      (N_CH),
        .TIMEOUT   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ready_o (cpu_ready),
        .cpu_err_o   (cpu_err),
        .is_io_o     (is_io),
        .stall_o     (stall),
        .ch_req_o    (ch_req),
        .ch_we_o     (ch_we),
        .ch_offset_o (ch_offset),
        .ch_wdata_o  (ch_wdata),
        .ch_rdata_i  (ch_rdata),
        .ch_ack_i    (ch_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        req;
        logic        exp_io;
        logic        exp_stall;
    } dec_vec_t;

    dec_vec_t vecs [8];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch_data(input int ch, input logic [31:0] d);
        ch_rdata[ch*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FC00, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{32'hFFFF_FC3F, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{32'hFFFF_FC40, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'hFFFF_FBFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FC10, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0000, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ch_rdata = '0; ch_ack = '0;
        #7;
        chk("reset ch_req", 32'(ch_req), 32'h0);
        chk("reset cpu_ready", 32'(cpu_ready), 32'h0);
        chk("reset cpu_rdata", cpu_rdata, 32'h0);
        chk("reset ch_we", 32'(ch_we), 32'h0);
        chk("reset stall", 32'(stall), 32'h0);
        #5 rst = 1'b0;
        tick();

        // Decode table, evaluated in IDLE; req drops before the edge so nothing is launched.
        for (int i = 0; i < 8; i++) begin
            cpu_addr = vecs[i].addr;
            cpu_req  = vecs[i].req;
            #1;
            chk($sformatf("decode[%0d] is_io", i), 32'(is_io), 32'(vecs[i].exp_io));
            chk($sformatf("decode[%0d] stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            cpu_req = 1'b0;
            tick();
            chk($sformatf("decode[%0d] ch_req", i), 32'(ch_req), 32'h0);
        end

        // Non-IO request held across an edge starts nothing.
        cpu_addr = 32'h0000_0100; cpu_req = 1'b1;
        tick();
        chk("non-io ch_req", 32'(ch_req), 32'h0);
        chk("non-io stall", 32'(stall), 32'h0);
        cpu_req = 1'b0;

        ch_ack = 4'hF;
        tick();
        chk("idle ack ready", 32'(cpu_ready), 32'h0);
        chk("idle ack ch_req", 32'(ch_req), 32'h0);
        ch_ack = '0;

        // Load from ch1, acked in cycle 1.
        cpu_addr = 32'hFFFF_FC10; cpu_we = 1'b0; cpu_req = 1'b1;
        #1;
        chk("load c0 stall", 32'(stall), 32'h1);
        tick();
        chk("load c1 ch_req", 32'(ch_req), 32'h2);
        chk("load c1 stall", 32'(stall), 32'h1);
        chk("load c1 ready", 32'(cpu_ready), 32'h0);
        ch_ack = 4'b0010; set_ch_data(1, 32'h0000_00A5);
        tick();
        chk("load c2 ready", 32'(cpu_ready), 32'h1);
        chk("load c2 rdata", cpu_rdata, 32'h0000_00A5);
        chk("load c2 stall", 32'(stall), 32'h0);
        chk("load c2 err", 32'(cpu_err), 32'h0);
        chk("load c2 ch_req", 32'(ch_req), 32'h0);
        cpu_req = 1'b0; ch_ack = '0;
        tick();
        chk("load c3 ready", 32'(cpu_ready), 32'h0);
        chk("load c3 rdata hold", cpu_rdata, 32'h0000_00A5);

        // Store to ch3, offset 4, ack after 5 cycles; store data changes under the latch.
        cpu_addr = 32'hFFFF_FC34; cpu_we = 1'b1; cpu_wdata = 32'h0000_1234; cpu_req = 1'b1;
        tick();
        cpu_wdata = 32'hFFFF_0000;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("store c%0d ch_req", c), 32'(ch_req), 32'h8);
            chk($sformatf("store c%0d ch_we", c), 32'(ch_we), 32'h1);
            chk($sformatf("store c%0d offset", c), 32'(ch_offset), 32'h4);
            chk($sformatf("store c%0d wdata", c), ch_wdata, 32'h0000_1234);
            chk($sformatf("store c%0d ready", c), 32'(cpu_ready), 32'h0);
            if (c == 5) ch_ack = 4'b1000;
            tick();
        end
        chk("store ready", 32'(cpu_ready), 32'h1);
        chk("store rdata", cpu_rdata, 32'h0);
        cpu_req = 1'b0; ch_ack = '0; cpu_we = 1'b0;
        tick();
        chk("store single pulse", 32'(cpu_ready), 32'h0);

        // Ch2 load with a stray ch0 ack and a moving address.
        set_ch_data(0, 32'hDEAD_BEEF); set_ch_data(2, 32'h5A5A_0002);
        cpu_addr = 32'hFFFF_FC20; cpu_req = 1'b1;
        tick();
        ch_ack = 4'b0001; cpu_addr = 32'hFFFF_FC00;
        tick();
        chk("stray ack ready", 32'(cpu_ready), 32'h0);
        chk("stray ack ch_req", 32'(ch_req), 32'h4);
        ch_ack = 4'b0100;
        tick();
        chk("ch2 ready", 32'(cpu_ready), 32'h1);
        chk("ch2 rdata", cpu_rdata, 32'h5A5A_0002);
        cpu_req = 1'b0; ch_ack = '0;
        tick();

        // Asynchronous reset in the middle of a store.
        cpu_addr = 32'hFFFF_FC1C; cpu_we = 1'b1; cpu_wdata = 32'h0000_0077; cpu_req = 1'b1;
        tick();
        chk("pre-rst ch_req", 32'(ch_req), 32'h2);
        rst = 1'b1;
        #1;
        chk("async rst ch_req", 32'(ch_req), 32'h0);
        chk("async rst ready", 32'(cpu_ready), 32'h0);
        chk("async rst rdata", cpu_rdata, 32'h0);
        chk("async rst ch_we", 32'(ch_we), 32'h0);
        chk("async rst offset", 32'(ch_offset), 32'h0);
        chk("async rst wdata", ch_wdata, 32'h0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        rst = 1'b0;
        set_ch_data(0, 32'h0000_1357);
        cpu_addr = 32'hFFFF_FC08; cpu_req = 1'b1;
        tick();
        chk("post-rst ch_req", 32'(ch_req), 32'h1);
        chk("post-rst offset", 32'(ch_offset), 32'h8);
        ch_ack = 4'b0001;
        tick();
        chk("post-rst ready", 32'(cpu_ready), 32'h1);
        chk("post-rst rdata", cpu_rdata, 32'h0000_1357);
        cpu_req = 1'b0; ch_ack = '0;
        tick();

`ifdef MMIO_TIMEOUT_EN
        // No ack: timeout completes 10 cycles after the request edge.
        set_ch_data(1, 32'h0000_0042);
        cpu_addr = 32'hFFFF_FC10; cpu_req = 1'b1;
        tick();
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("timeout c%0d ready", c), 32'(cpu_ready), 32'h0);
            chk($sformatf("timeout c%0d ch_req", c), 32'(ch_req), 32'h2);
            tick();
        end
        chk("timeout ready", 32'(cpu_ready), 32'h1);
        chk("timeout err", 32'(cpu_err), 32'h1);
        chk("timeout rdata", cpu_rdata, 32'hFFFF_FFFF);
        cpu_req = 1'b0;
        tick();
        chk("timeout err clears", 32'(cpu_err), 32'h0);

        // Ack in the timeout cycle wins.
        cpu_req = 1'b1;
        tick();
        for (int c = 1; c <= 9; c++) begin
            if (c == 9) ch_ack = 4'b0010;
            tick();
        end
        chk("late ack ready", 32'(cpu_ready), 32'h1);
        chk("late ack err", 32'(cpu_err), 32'h0);
        chk("late ack rdata", cpu_rdata, 32'h0000_0042);
        cpu_req = 1'b0; ch_ack = '0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
